// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Shift-add multiply, restoring divide, STEP bits per cycle.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int STEP  = 1,
  parameter int TAG_W = 5
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iValid,
  output logic             oReady,
  input  logic [2:0]       iFunct3,
  input  logic [XLEN-1:0]  iA,
  input  logic [XLEN-1:0]  iB,
  input  logic [TAG_W-1:0] iTag,
  input  logic             iFlush,
  output logic             oValid,
  input  logic             iReady,
  output logic [XLEN-1:0]  oResult,
  output logic [TAG_W-1:0] oTag,
  output logic             oBusy
);

  localparam int N  = XLEN / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CMAX = CW'(N - 1);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t              state;
  logic [2:0]          op;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [2*XLEN-1:0]   nxt;
  logic [XLEN-1:0]     mb;
  logic                neg_q;
  logic                neg_r;

  logic                sgn_a, sgn_b, a_neg, b_neg;
  logic                dz, ovf;
  logic [XLEN-1:0]     ma, mbi, fast;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem, res;

  assign oReady = (state == IDLE);
  assign oBusy  = (state != IDLE);

  assign sgn_a = iFunct3[2] ? !iFunct3[0]
                            : (iFunct3[1:0] != 2'b11);
  assign sgn_b = iFunct3[2] ? !iFunct3[0] : !iFunct3[1];
  assign a_neg = sgn_a & iA[XLEN-1];
  assign b_neg = sgn_b & iB[XLEN-1];
  assign ma    = a_neg ? -iA : iA;
  assign mbi   = b_neg ? -iB : iB;

  assign dz  = iFunct3[2] && (iB == '0);
  assign ovf = iFunct3[2] && !iFunct3[0]
            && (iA == MIN) && (iB == '1);

  // Divide-by-zero and signed overflow answers, chosen at accept
  always_comb begin
    fast = '0;
    if (dz) fast = iFunct3[1] ? iA : '1;
    else    fast = iFunct3[1] ? '0 : iA;
  end

  // Retire STEP bits: shift-add multiply or restoring divide
  always_comb begin
    logic [2*XLEN:0] wide;
    logic [XLEN:0]   diff;
    logic [XLEN:0]   sum;
    nxt  = acc;
    wide = '0;
    diff = '0;
    sum  = '0;
    for (int i = 0; i < STEP; i++) begin
      if (op[2]) begin
        wide = {nxt, 1'b0};
        diff = wide[2*XLEN:XLEN] - {1'b0, mb};
        if (!diff[XLEN])
          nxt = {diff[XLEN-1:0], wide[XLEN-1:1], 1'b1};
        else
          nxt = wide[2*XLEN-1:0];
      end else begin
        sum = {1'b0, nxt[2*XLEN-1:XLEN]}
            + (nxt[0] ? {1'b0, mb} : '0);
        nxt = {sum, nxt[XLEN-1:1]};
      end
    end
  end

  // Sign fixup and result select for the final CALC edge
  always_comb begin
    prod = neg_q ? -nxt : nxt;
    quo  = neg_q ? -nxt[XLEN-1:0] : nxt[XLEN-1:0];
    rem  = neg_r ? -nxt[2*XLEN-1:XLEN]
                 : nxt[2*XLEN-1:XLEN];
    res  = '0;
    unique case (op)
      3'b000:                 res = prod[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101:         res = quo;
      default:                res = rem;
    endcase
  end

  // Control FSM with registered result, tag and valid
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state   <= IDLE;
      op      <= '0;
      cnt     <= '0;
      acc     <= '0;
      mb      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      oValid  <= 1'b0;
      oResult <= '0;
      oTag    <= '0;
    end else if (iFlush) begin
      state  <= IDLE;
      oValid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (iValid) begin
            op    <= iFunct3;
            oTag  <= iTag;
            mb    <= mbi;
            acc   <= {{XLEN{1'b0}}, ma};
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            cnt   <= CMAX;
            if (dz || ovf) begin
              oResult <= fast;
              oValid  <= 1'b1;
              state   <= DONE;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          acc <= nxt;
          if (cnt == '0) begin
            oResult <= res;
            oValid  <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DONE: begin
          if (iReady) begin
            oValid <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: STEP=1 and STEP=4 instances
// share stimulus and are checked against a reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b1;
  logic [2:0]  f3 = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [4:0]  tag = '0;

  logic        rdy1, v1, busy1;
  logic        rdy4, v4, busy4;
  logic [31:0] r1, r4;
  logic [4:0]  t1, t4;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] MIN = 32'h8000_0000;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .STEP(1), .TAG_W(5)) u_dut (
    .iCLK(clk), .iRST(rst_n), .iValid(valid), .oReady(rdy1),
    .iFunct3(f3), .iA(a), .iB(b), .iTag(tag),
    .iFlush(flush), .oValid(v1), .iReady(ready),
    .oResult(r1), .oTag(t1), .oBusy(busy1)
  );

  muldiv_unit #(.XLEN(32), .STEP(4), .TAG_W(5)) u_dut4 (
    .iCLK(clk), .iRST(rst_n), .iValid(valid), .oReady(rdy4),
    .iFunct3(f3), .iA(a), .iB(b), .iTag(tag),
    .iFlush(flush), .oValid(v4), .iReady(ready),
    .oResult(r4), .oTag(t4), .oBusy(busy4)
  );

  typedef struct {
    logic [2:0]  f;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no result within cycle budget", nm);
  endtask

  function automatic logic [31:0] ref_model(
    input logic [2:0] f, input logic [31:0] x,
    input logic [31:0] y);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'({32'd0, x});
    longint uy = longint'({32'd0, y});
    logic [63:0] p;
    p = '0;
    case (f)
      3'd0: p = sx * sy;
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: if (y == 0) return '1; else p = sx / sy;
      3'd5: if (y == 0) return '1; else p = ux / uy;
      3'd6: if (y == 0) return x; else p = sx % sy;
      default: if (y == 0) return x; else p = ux % uy;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_fast(
    input logic [2:0] f, input logic [31:0] x,
    input logic [31:0] y);
    return f[2] && (y == 0 ||
           (!f[0] && x == MIN && y == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return MIN;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic issue(input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [4:0] t);
    @(negedge clk);
    valid = 1'b1; f3 = f; a = x; b = y; tag = t;
    @(posedge clk); #1;
    valid = 1'b0;
    a = $urandom; b = $urandom;
    f3 = 3'($urandom); tag = 5'($urandom);
    chk("accept", {busy1, busy4}, 2'b11);
  endtask

  task automatic collect(input string nm, input logic [31:0] exp,
                         input logic [4:0] t, input int l1,
                         input int l4);
    int n = 1;
    bit d1 = 1'b0;
    bit d4 = 1'b0;
    while (!(d1 && d4) && n <= 60) begin
      if (!d1 && v1) begin
        d1 = 1'b1;
        chk({nm, " res"}, r1, exp);
        chk({nm, " tag"}, t1, t);
        chk({nm, " lat"}, n, l1);
      end
      if (!d4 && v4) begin
        d4 = 1'b1;
        chk({nm, " res4"}, r4, exp);
        chk({nm, " lat4"}, n, l4);
      end
      if (!(d1 && d4)) begin
        @(posedge clk); #1;
        n++;
      end
    end
    if (!d1) timeout({nm, " wait"});
    if (!d4) timeout({nm, " wait4"});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] x, y;
    logic [4:0]  t;
    bit          fst, seen;
    int          n;

    vt[0]  = '{3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vt[1]  = '{3'b001, MIN, MIN, 32'h4000_0000, 33};
    vt[2]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 33};
    vt[3]  = '{3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33};
    vt[4]  = '{3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
    vt[5]  = '{3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
    vt[6]  = '{3'b101, 32'd100, 32'd7, 32'd14, 33};
    vt[7]  = '{3'b111, 32'd100, 32'd7, 32'd2, 33};
    vt[8]  = '{3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
    vt[9]  = '{3'b110, 32'd5, 32'd0, 32'd5, 1};
    vt[10] = '{3'b100, MIN, 32'hFFFF_FFFF, MIN, 1};
    vt[11] = '{3'b110, MIN, 32'hFFFF_FFFF, 32'd0, 1};

    // reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", {rdy1, rdy4}, 2'b11);
    chk("rst valid", {v1, v4}, 2'b00);
    chk("rst res", r1, 0);
    chk("rst tag", t1, 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("post rst ready", {rdy1, rdy4}, 2'b11);
    chk("post rst busy", {busy1, busy4}, 2'b00);

    // directed vectors
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].f, vt[i].x, vt[i].y, 5'(i + 1));
      collect($sformatf("vec%0d", i), vt[i].exp, 5'(i + 1),
              vt[i].lat, (vt[i].lat == 1) ? 1 : 9);
    end

    // random against reference model
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      x = pick();
      y = pick();
      t = 5'($urandom);
      fst = is_fast(f, x, y);
      issue(f, x, y, t);
      collect($sformatf("rand%0d f%0d %h %h", i, f, x, y),
              ref_model(f, x, y), t,
              fst ? 1 : 33, fst ? 1 : 9);
    end

    // backpressure: hold DONE for 5 cycles
    @(negedge clk) ready = 1'b0;
    issue(3'b000, 32'd12, 32'd11, 5'd9);
    n = 0;
    while (!v1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!v1) timeout("bp wait");
    for (int i = 0; i < 5; i++) begin
      chk("bp valid", {v1, v4}, 2'b11);
      chk("bp res", r1, 132);
      chk("bp res4", r4, 132);
      chk("bp tag", t1, 9);
      chk("bp ready", {rdy1, rdy4}, 2'b00);
      @(posedge clk); #1;
    end
    @(negedge clk) ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release ready", {rdy1, rdy4}, 2'b11);
    chk("bp release valid", {v1, v4}, 2'b00);
    issue(3'b101, 32'd100, 32'd7, 5'd3);
    collect("after bp", 32'd14, 5'd3, 33, 9);

    // flush at CALC cycle 10
    issue(3'b101, 32'd1000, 32'd3, 5'd4);
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush busy", busy1, 0);
    chk("flush valid", v1, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (v1) seen = 1'b1;
    end
    chk("flush no result", seen, 0);

    // request alongside flush is refused
    @(negedge clk);
    valid = 1'b1; flush = 1'b1;
    f3 = 3'b000; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    chk("flush blocks accept", {busy1, busy4}, 2'b00);

    // async reset mid-CALC
    issue(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd17);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst valid", {v1, v4}, 2'b00);
    chk("mid rst res", {r1, r4}, 0);
    chk("mid rst tag", {t1, t4}, 0);
    chk("mid rst busy", {busy1, busy4}, 2'b00);
    chk("mid rst ready", {rdy1, rdy4}, 2'b11);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (v1 || v4) seen = 1'b1;
    end
    chk("mid rst no result", seen, 0);

    issue(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd21);
    collect("after rst", 32'hFFFF_FFFF, 5'd21, 33, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
